// File: rtl/uart_pkg.sv
// Shared UART constants: 12 MHz baud divisors and receiver state encoding.
// Defining FSMRX_PARITY_EN widens the state register and adds the PARITY state.
package uart_pkg;

  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B9600   = 1250;
  localparam int B300    = 40000;

`ifdef FSMRX_PARITY_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  localparam logic [STATE_W-1:0] ST_IDLE  = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_START = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_DATA  = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_STOP  = STATE_W'(3);
`ifdef FSMRX_PARITY_EN
  localparam logic [STATE_W-1:0] ST_PARITY = STATE_W'(4);
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
`ifdef FSMRX_PARITY_EN
    S_PARITY = ST_PARITY,
`endif
    S_STOP   = ST_STOP
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fsmrx_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus one delay stage
// used to detect the start-bit falling edge.
module rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Reset to the idle-high line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = !sync_q && dly_q;

endmodule

// File: rtl/fsmrx.sv
// UART receiver (8N1, or 8E1 when FSMRX_PARITY_EN is defined) with mid-bit
// sampling; data/rcv/ferr/perr are registered, busy mirrors the state.
module fsmrx
  import uart_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx,
  output logic [7:0]         data,
  output logic               rcv,
  output logic               ferr,
  output logic               perr,
  output logic               busy,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD - 1);

  // Valid/ready does not apply here: rcv is a fire-and-forget one-cycle
  // strobe and data holds its value until the next good frame.

  logic rx_s;
  logic fall;

  rx_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  rx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2:0]     bit_q,   bit_d;
  logic [7:0]     sh_q,    sh_d;
  logic [7:0]     data_q,  data_d;
  logic           rcv_q,   rcv_d;
  logic           ferr_q,  ferr_d;
`ifdef FSMRX_PARITY_EN
  logic           perr_q,    perr_d;
  logic           par_bad_q, par_bad_d;
`endif
  logic           tick;

  assign tick = (state_q != S_IDLE) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      rcv_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef FSMRX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      rcv_q     <= rcv_d;
      ferr_q    <= ferr_d;
`ifdef FSMRX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q != S_IDLE && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    data_d    = data_q;
    rcv_d     = 1'b0;
    ferr_d    = 1'b0;
`ifdef FSMRX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Half-bit load puts every later sample in the middle of its bit.
        if (fall) begin
          cnt_d   = HALF_LD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = FULL_LD;
            bit_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          cnt_d = FULL_LD;
          if (bit_q == 3'd7) begin
`ifdef FSMRX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef FSMRX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_bad_d = (rx_s != even_parity(sh_q));
          cnt_d     = FULL_LD;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop-bit so the next start edge has half a bit of margin.
        if (tick) begin
          state_d = S_IDLE;
`ifdef FSMRX_PARITY_EN
          perr_d = par_bad_q;
          if (rx_s && !par_bad_q) begin
            data_d = sh_q;
            rcv_d  = 1'b1;
          end
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
`else
          if (rx_s) begin
            data_d = sh_q;
            rcv_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign rcv       = rcv_q;
  assign ferr      = ferr_q;
`ifdef FSMRX_PARITY_EN
  assign perr      = perr_q;
`else
  assign perr      = 1'b0;
`endif
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
